aes_key_expand_seq: RTL and testbench
=====================================

Name: aes_key_expand_seq

Overview:
- Sequential AES-128 key-schedule engine.
- Takes a 128-bit cipher key and streams the 11 round keys (round 0..NUM_ROUNDS) to the downstream round datapath, one per valid/ready handshake.
- Each cycle it forms the next round key from the current one: RotWord, SubWord, the round constant, and the XOR chain.
- It sits between the key register and the cipher rounds. It is the consumer of the round-constant lookup.

Parameters:
- NUM_ROUNDS, 10, index of the last round key emitted. Legal range 1..10; 10 gives full AES-128.

Ports:
- clk        input   1    rising-edge clock
- rst_n      input   1    asynchronous active-low reset
- start      input   1    begin expansion of key_in; sampled only in IDLE
- key_in     input   128  cipher key; bits [127:96] = w0, [31:0] = w3
- busy       output  1    high from the cycle after accepted start until the last round key handshakes
- rk_valid   output  1    rk_data/rk_round hold a valid round key
- rk_ready   input   1    downstream accepts the round key this cycle
- rk_round   output  4    round index of rk_data (0..NUM_ROUNDS)
- rk_data    output  128  round key, same word order as key_in
- done       output  1    one-cycle pulse after round NUM_ROUNDS is accepted

Behaviour:
- Reset (rst_n=0, asynchronous), all outputs and state cleared:
  - state=IDLE, busy=0, rk_valid=0, rk_round=0, rk_data=0, done=0.
- States: IDLE, RUN.
- IDLE:
  - start=1 at edge N latches key_in into the key register and sets rk_round=0. The next state is RUN.
  - From N+1: rk_valid=1, busy=1, rk_data=key_in (round 0 is the key itself).
- RUN:
  - rk_valid stays 1. rk_data and rk_round hold stable while rk_ready=0 (no drop, no change).
- Handshake in RUN (rk_valid & rk_ready) when rk_round < NUM_ROUNDS:
  - Next cycle: rk_data = next_key(rk_data, rcon(rk_round+1)), rk_round incremented. No bubble.
- Handshake when rk_round == NUM_ROUNDS:
  - Next cycle: state=IDLE, rk_valid=0, busy=0, done=1 for exactly one cycle. rk_data and rk_round keep their last values.
- next_key(w0..w3, rc):
  - t = SubWord(RotWord(w3)) ^ {rc,24'h0}, where RotWord({a,b,c,d}) = {b,c,d,a} and SubWord applies the AES S-box per byte.
  - w4 = w0^t; w5 = w1^w4; w6 = w2^w5; w7 = w3^w6.
  - All arithmetic is 32-bit XOR; no carries.
- rcon(i), i=1..10: 01,02,04,08,10,20,40,80,1b,36. Any other i returns 00; it is never used.
- Throughput and latency with rk_ready held high:
  - 1 round key per cycle.
  - start at edge N gives round k at cycle N+1+k. done is high in cycle N+2+NUM_ROUNDS.
- start while busy (RUN): ignored; key_in is not sampled. start in the same cycle that done is high is accepted (state is IDLE).
- rk_ready while rk_valid=0: ignored.
- Reset asserted mid-expansion: immediate return to reset values; no done pulse. After release the block waits in IDLE for a new start.
- Critical path is one S-box level plus a 4-deep XOR chain; no pipelining.

Decomposition:
- Shared package aes_pkg holds:
  - constant AES_SBOX (256 x 8-bit);
  - function rcon_byte(round index) returning the 8-bit round constant;
  - functions rot_word and sub_word;
  - typedef aes_word_t (32 bits);
  - constant AES128_NR = 10.
- One sub-module, aes_sub_word: a purely combinational 32-bit SubWord (four S-box instances), instantiated once on w3.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - round0 = key; round1 = a0fafe1788542cb123a339392a6c7605; round2 = f2c295f27a96b9435935807a7359f67f; round10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done exactly 12 cycles after start.
- All-zero key:
  - round1 = 62636363626363636263636362636363; round10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure: FIPS key, rk_ready toggled randomly (about 50%):
  - rk_data and rk_round stable whenever rk_valid & !rk_ready.
  - The same 11 keys arrive in order; done pulses once.
- start re-pulsed with a different key during RUN:
  - Ignored; the sequence still matches the first key.
- start held high through done:
  - A second expansion begins the cycle after done; round 0 = the new key_in value.
- rst_n pulsed low at round 5:
  - Outputs are zero immediately; no done.
  - A fresh start afterwards reproduces the correct sequence from round 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES helpers: S-box table, round constants and word-level primitives.
package aes_pkg;

  typedef logic [31:0] aes_word_t;

  // Number of rounds in AES-128; also the index of its last round key.
  localparam int AES128_NR = 10;

  // Forward AES S-box, indexed by the input byte.
  localparam logic [7:0] AES_SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Round constant byte for round keys 1..10; anything else yields zero.
  function automatic logic [7:0] rcon_byte(input logic [3:0] round_idx);
    logic [7:0] rc;
    case (round_idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Cyclic left rotation by one byte: {a,b,c,d} -> {b,c,d,a}.
  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  // Byte-wise S-box substitution of a whole word.
  function automatic aes_word_t sub_word(input aes_word_t w);
    aes_word_t r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = AES_SBOX[w[8*i +: 8]];
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four parallel S-box lookups, one per byte lane.
module aes_sub_word
  import aes_pkg::*;
(
  input  aes_word_t word_i,
  output aes_word_t word_o
);

  // One S-box per byte lane; lanes are independent so rotation may be applied before or after.
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign word_o[8*i +: 8] = AES_SBOX[word_i[8*i +: 8]];
  end

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128 key schedule: emits round keys 0..NUM_ROUNDS over a valid/ready stream,
// computing each next round key in a single cycle from the one currently presented.
module aes_key_expand_seq
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_NR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_round,
  output logic [127:0] rk_data,
  output logic         done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  logic [0:0]   state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic         done_q, done_d;

  aes_word_t w0, w1, w2, w3;
  aes_word_t sub_w3, t_word;
  aes_word_t w4, w5, w6, w7;

  // The presented round key doubles as the working key register.
  assign {w0, w1, w2, w3} = key_q;

  aes_sub_word u_sub_word (
    .word_i (w3),
    .word_o (sub_w3)
  );

  // SubWord is byte-wise, so rotating after substitution equals SubWord(RotWord(w3)).
  assign t_word = rot_word(sub_w3) ^ {rcon_byte(round_q + 4'd1), 24'h000000};
  assign w4 = w0 ^ t_word;
  assign w5 = w1 ^ w4;
  assign w6 = w2 ^ w5;
  assign w7 = w3 ^ w6;

  // Next-state: accept start in IDLE, advance the key on each handshake, finish after the last one.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d   = key_in;
          round_d = 4'd0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (rk_ready) begin
          if (round_q == LAST_ROUND) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            key_d   = {w4, w5, w6, w7};
            round_d = round_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset clears everything so no stale key is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign rk_valid = (state_q == ST_RUN);
  assign rk_round = round_q;
  assign rk_data  = key_q;
  assign done     = done_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Directed testbench for aes_key_expand_seq using FIPS-197 and all-zero key vectors.
module tb_aes_key_expand_seq;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [3:0]   rk_round;
  logic [127:0] rk_data;
  logic         done;

  int tests_run;
  int tests_failed;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_KEY = 128'h0;

  logic [127:0] fips_rk [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  aes_key_expand_seq #(.NUM_ROUNDS(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_round (rk_round),
    .rk_data  (rk_data),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives a one-cycle start (held unless the caller clears it) with rk_ready high.
  task automatic applyStimulus(input logic [127:0] key);
    @(negedge clk);
    key_in   = key;
    start    = 1'b1;
    rk_ready = 1'b1;
  endtask

  // Full FIPS expansion with rk_ready held high, including done timing.
  task automatic checkFipsRun(input string tag);
    applyStimulus(FIPS_KEY);
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, "_busy_r0"}, 128'(busy), 128'd1);
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) @(negedge clk);
      checkOutput($sformatf("%s_valid_r%0d", tag, k), 128'(rk_valid), 128'd1);
      checkOutput($sformatf("%s_round_r%0d", tag, k), 128'(rk_round), 128'(k));
      checkOutput($sformatf("%s_data_r%0d", tag, k), rk_data, fips_rk[k]);
      checkOutput($sformatf("%s_nodone_r%0d", tag, k), 128'(done), 128'd0);
    end
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 128'(done), 128'd1);
    checkOutput({tag, "_done_valid"}, 128'(rk_valid), 128'd0);
    checkOutput({tag, "_done_busy"}, 128'(busy), 128'd0);
    checkOutput({tag, "_done_hold_data"}, rk_data, fips_rk[10]);
    checkOutput({tag, "_done_hold_round"}, 128'(rk_round), 128'd10);
    @(negedge clk);
    checkOutput({tag, "_done_one_cycle"}, 128'(done), 128'd0);
  endtask

  initial begin
    logic         stall;
    logic         seen_done;
    logic [127:0] prev_data;
    logic [3:0]   prev_round;
    int           idx;
    int           done_count;

    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    rk_ready     = 1'b0;
    key_in       = '0;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 128'(busy), 128'd0);
    checkOutput("rst_valid", 128'(rk_valid), 128'd0);
    checkOutput("rst_round", 128'(rk_round), 128'd0);
    checkOutput("rst_data", rk_data, 128'd0);
    checkOutput("rst_done", 128'(done), 128'd0);
    rst_n = 1'b1;

    // rk_ready while idle must not start anything
    @(negedge clk);
    rk_ready = 1'b1;
    @(negedge clk);
    checkOutput("idle_ready_valid", 128'(rk_valid), 128'd0);

    // FIPS-197 key, no backpressure
    checkFipsRun("fips");

    // All-zero key, no backpressure
    applyStimulus(ZERO_KEY);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0) checkOutput("zero_r0", rk_data, 128'h0);
      if (k == 1) checkOutput("zero_r1", rk_data, 128'h62636363626363636263636362636363);
      if (k == 2) checkOutput("zero_r2", rk_data, 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa);
      if (k == 10) checkOutput("zero_r10", rk_data, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    end
    @(negedge clk);
    checkOutput("zero_done", 128'(done), 128'd1);

    // Backpressure with stray start pulses carrying a different key
    @(negedge clk);
    key_in   = FIPS_KEY;
    start    = 1'b1;
    rk_ready = 1'b0;
    stall      = 1'b0;
    seen_done  = 1'b0;
    prev_data  = '0;
    prev_round = '0;
    idx        = 0;
    done_count = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (stall) begin
        checkOutput($sformatf("bp_stable_data_c%0d", cyc), rk_data, prev_data);
        checkOutput($sformatf("bp_stable_round_c%0d", cyc), 128'(rk_round), 128'(prev_round));
        checkOutput($sformatf("bp_stable_valid_c%0d", cyc), 128'(rk_valid), 128'd1);
      end
      if (done) begin
        seen_done = 1'b1;
        done_count++;
        break;
      end
      key_in   = ZERO_KEY;
      start    = (idx >= 2 && idx <= 8) ? 1'($urandom_range(0, 1)) : 1'b0;
      rk_ready = 1'($urandom_range(0, 1));
      if (rk_valid && rk_ready) begin
        checkOutput($sformatf("bp_round_%0d", idx), 128'(rk_round), 128'(idx));
        checkOutput($sformatf("bp_data_%0d", idx), rk_data, fips_rk[idx < 11 ? idx : 10]);
        idx++;
      end
      stall      = rk_valid && !rk_ready;
      prev_data  = rk_data;
      prev_round = rk_round;
    end
    start = 1'b0;
    checkOutput("bp_seen_done", 128'(seen_done), 128'd1);
    checkOutput("bp_key_count", 128'(idx), 128'd11);
    @(negedge clk);
    if (done) done_count++;
    checkOutput("bp_done_once", 128'(done_count), 128'd1);
    rk_ready = 1'b1;

    // start held high through done: second expansion begins the cycle after done
    applyStimulus(FIPS_KEY);
    @(negedge clk);
    checkOutput("hold_r0", rk_data, fips_rk[0]);
    key_in = ZERO_KEY;
    @(negedge clk);
    checkOutput("hold_ignored_r1", rk_data, fips_rk[1]);
    repeat (9) @(negedge clk);
    checkOutput("hold_r10", rk_data, fips_rk[10]);
    @(negedge clk);
    checkOutput("hold_done", 128'(done), 128'd1);
    @(negedge clk);
    start = 1'b0;
    checkOutput("hold_restart_valid", 128'(rk_valid), 128'd1);
    checkOutput("hold_restart_round", 128'(rk_round), 128'd0);
    checkOutput("hold_restart_data", rk_data, ZERO_KEY);

    // Reset asserted at round 5 of the running expansion
    repeat (5) @(negedge clk);
    checkOutput("midrst_at_r5", 128'(rk_round), 128'd5);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 128'(rk_valid), 128'd0);
    checkOutput("midrst_busy", 128'(busy), 128'd0);
    checkOutput("midrst_round", 128'(rk_round), 128'd0);
    checkOutput("midrst_data", rk_data, 128'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("midrst_nodone_%0d", c), 128'(done), 128'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post_rst_idle", 128'(rk_valid), 128'd0);
    checkOutput("post_rst_nodone", 128'(done), 128'd0);

    // Fresh expansion after reset reproduces the full sequence
    checkFipsRun("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
